// File: rtl/phy_rx_pkg.sv
// Shared definitions for the serial RX deserializer: default parameter
// constants and the output-gating FSM state type.
package phy_rx_pkg;

  localparam int DEF_CHANNELS    = 1;
  localparam int DEF_WORD_W      = 8;
  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_PREFILL     = 2;

  // ST_PREFILL: buffering, output held invalid.
  // ST_STREAM : head word presented while the buffer is non-empty.
  typedef enum logic [0:0] {
    ST_PREFILL = 1'b0,
    ST_STREAM  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/phy_rx_fwft_fifo.sv
// First-word-fall-through buffer with occupancy count. A push while full
// is accepted only when a pop happens on the same edge; otherwise the new
// word is dropped and 'drop' flags it. count_nxt is the post-edge
// occupancy so the owner can make same-edge decisions.
module phy_rx_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_nxt,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // Accept/drop decisions and next occupancy for this edge.
  always_comb begin
    full      = (count == FULL_CNT);
    pop_ok    = pop && (count != '0);
    push_ok   = push && (!full || pop_ok);
    drop      = push && full && !pop_ok;
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Head entry falls through to the output.
  assign rdata = mem[rd_ptr];

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/phy_rx_deser.sv
// Multi-lane serial RX deserializer: per-lane synchronizer, shared bit
// counter, MSB-first shift registers, FWFT output buffer gated by a
// PREFILL/STREAM FSM.
// Optional build macro: PHY_RX_DESER_GLITCH_FILTER_EN replaces each lane's
// synchronized bit by a 3-sample majority vote (two extra cycles of latency).
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_accept are both high; while out_valid is high and out_accept is low,
// RX_sampled is held stable. out_valid never depends on out_accept.
module phy_rx_deser
  import phy_rx_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int PREFILL     = DEF_PREFILL
) (
  input  logic                           clk_160mhz,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            RX,
  input  logic                           out_accept,
  output logic                           out_valid,
  output logic [CHANNELS*WORD_W-1:0]     RX_sampled,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           overflow,
  output logic                           underrun,
  output rx_state_e                      fsm_state
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WORD_W - 1);
  localparam logic [FCW-1:0]   PREFILL_CNT = FCW'(PREFILL);

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [CHANNELS-1:0]                  stable;
  logic [CHANNELS-1:0]                  lane_bit;
  logic [CHANNELS-1:0][WORD_W-2:0]      hist_q;
  logic [CHANNELS-1:0][WORD_W-1:0]      word_nxt;
  logic [CNT_W-1:0]                     bit_cnt;
  logic                                 word_end;
  logic                                 pop;
  logic [FCW-1:0]                       count_nxt;
  logic                                 drop;
  rx_state_e                            state_q;
  rx_state_e                            state_d;
  logic                                 underrun_d;

  // Synchronizer chains: RX enters at bit 0, stable bit leaves the top stage.
  always_ff @(posedge clk_160mhz or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], RX[i]};
    end
  end

  // Pick out each lane's stable (fully synchronized) bit.
  always_comb begin
    stable = '0;
    for (int i = 0; i < CHANNELS; i++)
      stable[i] = sync_q[i][SYNC_STAGES-1];
  end

`ifdef PHY_RX_DESER_GLITCH_FILTER_EN
  logic [CHANNELS-1:0][2:0] filt_q;

  // Last three stable samples per lane for the majority vote.
  always_ff @(posedge clk_160mhz or posedge reset) begin
    if (reset) begin
      filt_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        filt_q[i] <= {filt_q[i][1:0], stable[i]};
    end
  end

  // Majority of three rejects single-cycle glitches.
  always_comb begin
    lane_bit = '0;
    for (int i = 0; i < CHANNELS; i++)
      lane_bit[i] = (filt_q[i][0] & filt_q[i][1]) |
                    (filt_q[i][0] & filt_q[i][2]) |
                    (filt_q[i][1] & filt_q[i][2]);
  end
`else
  // Stable bit goes straight into the shift register.
  always_comb begin
    lane_bit = stable;
  end
`endif

  assign word_end = (bit_cnt == CNT_LAST);

  // Shared free-running bit counter, 0..WORD_W-1.
  always_ff @(posedge clk_160mhz or posedge reset) begin
    if (reset)         bit_cnt <= '0;
    else if (word_end) bit_cnt <= '0;
    else               bit_cnt <= bit_cnt + 1'b1;
  end

  // Word as it stands after this cycle's bit; pushed when the counter ends.
  always_comb begin
    word_nxt = '0;
    for (int i = 0; i < CHANNELS; i++)
      word_nxt[i] = {hist_q[i], lane_bit[i]};
  end

  // Shift history: only WORD_W-1 bits need keeping, the oldest falls off.
  always_ff @(posedge clk_160mhz or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        hist_q[i] <= word_nxt[i][WORD_W-2:0];
    end
  end

  assign pop = out_valid && out_accept;

  phy_rx_fwft_fifo #(
    .WIDTH (CHANNELS*WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_160mhz),
    .reset     (reset),
    .push      (word_end),
    .pop       (pop),
    .wdata     (word_nxt),
    .rdata     (RX_sampled),
    .count     (fifo_count),
    .count_nxt (count_nxt),
    .drop      (drop)
  );

  // Sticky record that a completed word was lost to a full buffer.
  always_ff @(posedge clk_160mhz or posedge reset) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  // FSM next state: decisions use the post-edge occupancy.
  always_comb begin
    state_d    = state_q;
    underrun_d = 1'b0;
    case (state_q)
      ST_PREFILL: begin
        if (count_nxt >= PREFILL_CNT) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (count_nxt == '0) begin
          state_d    = ST_PREFILL;
          underrun_d = 1'b1;
        end
      end
      default: state_d = ST_PREFILL;
    endcase
  end

  // FSM state and one-cycle underrun pulse.
  always_ff @(posedge clk_160mhz or posedge reset) begin
    if (reset) begin
      state_q  <= ST_PREFILL;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      underrun <= underrun_d;
    end
  end

  assign out_valid = (state_q == ST_STREAM) && (fifo_count != '0);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_phy_rx_deser.sv
// Directed bench for phy_rx_deser: default instance (1 lane x 8 bits) plus
// a 2-lane x 4-bit instance sharing clock and reset.
module tb_phy_rx_deser;
  import phy_rx_pkg::*;

`ifdef PHY_RX_DESER_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk;
  logic       reset;
  logic [0:0] rx;
  logic       out_accept;
  logic       out_valid;
  logic [7:0] rx_sampled;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       underrun;
  rx_state_e  fsm_state;

  logic [1:0] rx2;
  logic       out_accept2;
  logic       out_valid2;
  logic [7:0] rx_sampled2;
  logic [2:0] fifo_count2;
  logic       overflow2;
  logic       underrun2;
  rx_state_e  fsm_state2;

  int tests = 0;
  int fails = 0;

  phy_rx_deser u_dut (
    .clk_160mhz (clk),
    .reset      (reset),
    .RX         (rx),
    .out_accept (out_accept),
    .out_valid  (out_valid),
    .RX_sampled (rx_sampled),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .underrun   (underrun),
    .fsm_state  (fsm_state)
  );

  phy_rx_deser #(
    .CHANNELS (2),
    .WORD_W   (4)
  ) u_dut2 (
    .clk_160mhz (clk),
    .reset      (reset),
    .RX         (rx2),
    .out_accept (out_accept2),
    .out_valid  (out_valid2),
    .RX_sampled (rx_sampled2),
    .fifo_count (fifo_count2),
    .overflow   (overflow2),
    .underrun   (underrun2),
    .fsm_state  (fsm_state2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word built from constant-1 input: edge e (1-based after release)
  // carries a 1 only once e exceeds the input latency; first edge -> MSB.
  function automatic logic [7:0] ones_word(input int first_edge, input int w);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < w; k++)
      if (first_edge + k > LAT) v[w-1-k] = 1'b1;
    return v;
  endfunction

  logic [7:0] w1;
  logic [7:0] pat;
  logic [7:0] glitch_exp;

  initial begin
    reset       = 1'b1;
    rx          = 1'b1;
    out_accept  = 1'b0;
    rx2         = 2'b01;
    out_accept2 = 1'b0;
    w1          = ones_word(1, 8);
    pat         = 8'hA5;
    tick();
    tick();

    // Reset state
    check("rst_valid",    32'(out_valid),  32'd0);
    check("rst_count",    32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    check("rst_underrun", 32'(underrun),   32'd0);
    check("rst_state",    32'(fsm_state),  32'(ST_PREFILL));

    // Constant-1 input, no consumer: prefill, stall, saturation, overflow
    reset = 1'b0;
    repeat (7) tick();
    check("a_cnt_e7", 32'(fifo_count), 32'd0);
    tick();
    check("a_cnt_e8",   32'(fifo_count), 32'd1);
    check("a_valid_e8", 32'(out_valid),  32'd0);
    check("b_cnt_e8",   32'(fifo_count2), 32'd2);
    check("b_valid_e8", 32'(out_valid2),  32'd1);
    check("b_head1",    32'(rx_sampled2), {24'd0, 4'h0, ones_word(1, 4)[3:0]});
    out_accept2 = 1'b1;
    tick();
    out_accept2 = 1'b0;
    check("b_cnt_e9", 32'(fifo_count2), 32'd1);
    check("b_head2",  32'(rx_sampled2), {24'd0, 4'h0, ones_word(5, 4)[3:0]});

    repeat (7) tick();
    check("a_cnt_e16",   32'(fifo_count), 32'd2);
    check("a_valid_e16", 32'(out_valid),  32'd1);
    check("a_state_e16", 32'(fsm_state),  32'(ST_STREAM));
    check("a_head_e16",  32'(rx_sampled), 32'(w1));
    repeat (8) tick();
    check("a_cnt_e24",  32'(fifo_count), 32'd3);
    check("a_hold_e24", 32'(rx_sampled), 32'(w1));
    repeat (8) tick();
    check("a_cnt_e32", 32'(fifo_count), 32'd4);
    check("a_ovf_e32", 32'(overflow),   32'd0);
    repeat (8) tick();
    check("a_cnt_e40", 32'(fifo_count), 32'd4);
    check("a_ovf_e40", 32'(overflow),   32'd1);
    repeat (8) tick();
    check("a_cnt_e48",  32'(fifo_count), 32'd4);
    check("a_head_e48", 32'(rx_sampled), 32'(w1));

    // Drain the four buffered words one per cycle
    out_accept = 1'b1;
    tick();
    check("a_pop1_head", 32'(rx_sampled), 32'hFF);
    check("a_pop1_cnt",  32'(fifo_count), 32'd3);
    tick();
    check("a_pop2_head", 32'(rx_sampled), 32'hFF);
    tick();
    check("a_pop3_head", 32'(rx_sampled), 32'hFF);
    check("a_pop3_cnt",  32'(fifo_count), 32'd1);
    tick();
    out_accept = 1'b0;
    check("a_drain_cnt",   32'(fifo_count), 32'd0);
    check("a_drain_valid", 32'(out_valid),  32'd0);
    check("a_drain_udr",   32'(underrun),   32'd1);
    check("a_drain_state", 32'(fsm_state),  32'(ST_PREFILL));
    tick();
    check("a_udr_pulse", 32'(underrun), 32'd0);
    check("a_ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset mid-word / mid-stream
    #3;
    reset = 1'b1;
    #1;
    check("r_ovf",    32'(overflow),    32'd0);
    check("r_cnt",    32'(fifo_count),  32'd0);
    check("r_valid",  32'(out_valid),   32'd0);
    check("r_valid2", 32'(out_valid2),  32'd0);
    check("r_cnt2",   32'(fifo_count2), 32'd0);
    tick();
    tick();

    // Continuous consumer: prefill, immediate drain, underrun
    out_accept = 1'b1;
    reset      = 1'b0;
    repeat (8) tick();
    check("c_cnt_e8",   32'(fifo_count), 32'd1);
    check("c_valid_e8", 32'(out_valid),  32'd0);
    repeat (8) tick();
    check("c_valid_e16", 32'(out_valid),  32'd1);
    check("c_head_e16",  32'(rx_sampled), 32'(w1));
    check("c_cnt_e16",   32'(fifo_count), 32'd2);
    tick();
    check("c_head_e17", 32'(rx_sampled), 32'hFF);
    check("c_cnt_e17",  32'(fifo_count), 32'd1);
    tick();
    check("c_cnt_e18",   32'(fifo_count), 32'd0);
    check("c_valid_e18", 32'(out_valid),  32'd0);
    check("c_udr_e18",   32'(underrun),   32'd1);
    check("c_state_e18", 32'(fsm_state),  32'(ST_PREFILL));
    tick();
    check("c_udr_e19", 32'(underrun), 32'd0);
    out_accept = 1'b0;
    reset      = 1'b1;
    tick();
    tick();

    // 8'hA5 MSB-first, aligned so bit 7 is captured on counter=0
    reset = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      rx = pat[7 - ((n + LAT - 1) % 8)];
      tick();
    end
    check("p_cnt_e24",  32'(fifo_count), 32'd3);
    check("p_head1",    32'(rx_sampled), 32'(pat & (8'hFF >> LAT)));
    out_accept = 1'b1;
    for (int n = 25; n <= 26; n++) begin
      rx = pat[7 - ((n + LAT - 1) % 8)];
      tick();
      check("p_head_ss", 32'(rx_sampled), 32'hA5);
    end
    out_accept = 1'b0;
    check("p_cnt_e26", 32'(fifo_count), 32'd1);
    reset = 1'b1;
    tick();
    tick();

    // Single-cycle glitch on a quiet line
`ifdef PHY_RX_DESER_GLITCH_FILTER_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    rx    = 1'b0;
    reset = 1'b0;
    tick();
    rx = 1'b1;
    tick();
    rx = 1'b0;
    repeat (14) tick();
    check("g_cnt",   32'(fifo_count), 32'd2);
    check("g_word1", 32'(rx_sampled), 32'(glitch_exp));
    out_accept = 1'b1;
    tick();
    out_accept = 1'b0;
    check("g_word2", 32'(rx_sampled), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/phy_rx_deser.md
PHY_RX_DESER -- requirements
Module: phy_rx_deser

Interface
REQ-001 Parameter CHANNELS, default 1: number of independent serial RX lanes.
REQ-002 Parameter WORD_W, default 8: bits per deserialized word per lane, range 2..32.
REQ-003 Parameter SYNC_STAGES, default 3: metastability flops per lane, range 2..4.
REQ-004 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two, range 2..16.
REQ-005 Parameter PREFILL, default 2: entries buffered before output starts, range 1..FIFO_DEPTH.
REQ-006 clk_160mhz  input  1  sole clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 RX  input  CHANNELS  raw asynchronous serial inputs, bit i = lane i.
REQ-009 out_accept  input  1  consumer takes head word this cycle when out_valid is high.
REQ-010 out_valid  output  1  RX_sampled holds a valid word.
REQ-011 RX_sampled  output  CHANNELS*WORD_W  head word; lane i occupies bits [i*WORD_W +: WORD_W].
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-013 overflow  output  1  sticky; a completed word was dropped.
REQ-014 underrun  output  1  one-cycle pulse when STREAM drains to empty.

Function
REQ-015 Each lane SHALL pass RX through SYNC_STAGES flops; the last stage is the stable bit.
REQ-016 Bit counter SHALL count 0..WORD_W-1 every cycle, wrap to 0, and be shared by all lanes.
REQ-017 Each lane shift register SHALL shift left one stable bit per cycle; the first bit of a word lands in the MSB.
REQ-018 When the counter equals WORD_W-1, all lanes' words (including that cycle's bit) SHALL be pushed as one FIFO entry on that edge.
REQ-019 The FIFO SHALL be first-word-fall-through: RX_sampled = head entry, stable while out_valid && !out_accept.
REQ-020 Pop occurs iff out_valid && out_accept; RX_sampled is a don't-care when out_valid is low.
REQ-021 Push with pop on the same edge SHALL leave fifo_count unchanged, including when full.
REQ-022 Push when full with no pop SHALL drop the new word, leave FIFO contents intact, and set overflow until reset.
REQ-023 FSM states: PREFILL, STREAM. PREFILL: out_valid=0; go to STREAM on the edge where fifo_count (post-update) >= PREFILL.
REQ-024 STREAM: out_valid=1 whenever fifo_count>0; if fifo_count becomes 0, pulse underrun for one cycle and return to PREFILL.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL saturate at exactly FIFO_DEPTH.

Reset
REQ-026 Reset SHALL asynchronously clear sync flops, shift registers, bit counter, FIFO pointers, fifo_count, overflow, and underrun, and force state PREFILL with out_valid=0.
REQ-027 Reset asserted mid-word or mid-stream SHALL discard all partial and buffered data; the first post-reset word begins on the counter=0 cycle after release.

Configuration
REQ-028 Macro PHY_RX_DESER_GLITCH_FILTER_EN defined: each lane's stable bit SHALL be replaced by the majority of its last three stable samples, adding 2 cycles of latency; filter flops reset to 0.
REQ-029 Macro undefined: no filter logic; the stable bit feeds the shift register directly.

Structure
REQ-030 Shared package phy_rx_pkg SHALL hold the FSM state enum (PREFILL, STREAM) and default parameter constants.
REQ-031 FIFO SHALL be one sub-module, phy_rx_fwft_fifo (parametrised width/depth, FWFT, count output).

Verification
REQ-032 Defaults, RX held 1 after reset release: first push at cycle 8 = 8'b00011111 (3 reset-zero sync bits); out_valid rises after the second push; all later words = 8'hFF.
REQ-033 Defaults, RX driven with pattern 8'hA5 MSB-first aligned to counter=0 after sync latency: every steady-state word = 8'hA5.
REQ-034 out_accept=0 for 6 words: fifo_count saturates at 4, overflow=1 after the 5th push, and the first 4 words are intact when read.
REQ-035 out_accept=1 continuously: after the 2-entry prefill, each pop drains faster than fill; underrun pulses once, FSM returns to PREFILL, and out_valid falls.
REQ-036 CHANNELS=2, WORD_W=4, lane0 constant 1, lane1 constant 0: steady-state RX_sampled = 8'h0F; reset pulse mid-word clears out_valid and fifo_count within the same cycle.
REQ-037 Filter macro defined, single-cycle 1 glitch on RX=0: words remain 8'h00; macro undefined: one bit set.
